// File: rtl/tea_pkg.sv
// Shared TEA definitions for the 16-bit-half encryptor/decryptor pair:
// APB register addresses, key layout and the half-round mixing function.
package tea_pkg;

  localparam logic [31:0] TEA_ADDR_KEY10 = 32'h0000_0000;
  localparam logic [31:0] TEA_ADDR_KEY32 = 32'h0000_0004;
  localparam logic [31:0] TEA_ADDR_DELTA = 32'h0000_0008;
  localparam logic [31:0] TEA_ADDR_ROUNDS = 32'h0000_000C;

  // Packed so that {k3,k2,k1,k0} lines up with the 64-bit KEY parameter.
  typedef struct packed {
    logic [15:0] k3;
    logic [15:0] k2;
    logic [15:0] k1;
    logic [15:0] k0;
  } tea_key_t;

  // All terms are 16 bits wide, so <<4 truncates and the sums wrap mod 2^16.
  function automatic logic [15:0] tea_f(input logic [15:0] v,
                                        input logic [15:0] sum,
                                        input logic [15:0] ka,
                                        input logic [15:0] kb);
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tinydec_if.sv
// Block handshake (req/ack/wdata/rdata) and APB slave bundle for tinydec.
interface tinydec_if;

  logic        req;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport slave (
    input  req, wdata, psel, penable, pwrite, paddr, pwdata,
    output ack, rdata, prdata, pready
  );

  modport master (
    output req, wdata, psel, penable, pwrite, paddr, pwdata,
    input  ack, rdata, prdata, pready
  );

endinterface

// File: rtl/tinydec_regs.sv
// APB register file for tinydec: key, delta and (with TINYDEC_ROUND_REG_EN)
// a runtime round count. Reads are registered on every posedge with psel=1.
module tinydec_regs
  import tea_pkg::*;
#(
  parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
  parameter logic [15:0] DELTA = 16'h1,
  parameter logic [7:0]  ROUND = 8'd5
) (
  input  logic        clk,
  input  logic        prstb,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output tea_key_t    key,
  output logic [15:0] delta,
  output logic [7:0]  rounds
);

  logic        wr_en;
  logic [31:0] rd_data;

  assign wr_en = psel & penable & pwrite;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge prstb) begin
    if (!prstb) begin
      key   <= tea_key_t'(KEY);
      delta <= DELTA;
    end else if (wr_en) begin
      case (paddr)
        TEA_ADDR_KEY10: {key.k1, key.k0} <= pwdata;
        TEA_ADDR_KEY32: {key.k3, key.k2} <= pwdata;
        TEA_ADDR_DELTA: delta <= pwdata[15:0];
        default: ;
      endcase
    end
  end

`ifdef TINYDEC_ROUND_REG_EN
  always_ff @(posedge clk or negedge prstb) begin
    if (!prstb) begin
      rounds <= ROUND;
    end else if (wr_en && paddr == TEA_ADDR_ROUNDS) begin
      rounds <= pwdata[7:0];
    end
  end
`else
  assign rounds = ROUND;
`endif

  // NOTE: the read mux assigns a default before the case so no latch is
  // inferred for unmapped addresses.
  always_comb begin
    rd_data = '0;
    case (paddr)
      TEA_ADDR_KEY10: rd_data = {key.k1, key.k0};
      TEA_ADDR_KEY32: rd_data = {key.k3, key.k2};
      TEA_ADDR_DELTA: rd_data = {16'h0, delta};
`ifdef TINYDEC_ROUND_REG_EN
      TEA_ADDR_ROUNDS: rd_data = {24'h0, rounds};
`endif
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge prstb) begin
    if (!prstb) begin
      prdata <= '0;
    end else if (psel) begin
      prdata <= rd_data;
    end
  end

endmodule

// File: rtl/tinydec.sv
// 16-bit-half TEA decryptor: one 32-bit block per req/ack handshake, one
// inverse round per clock. Optional runtime round count: TINYDEC_ROUND_REG_EN.
module tinydec
  import tea_pkg::*;
#(
  parameter logic [63:0] KEY   = 64'h816fc52b09e74da3,
  parameter logic [15:0] DELTA = 16'h1,
  parameter logic [7:0]  ROUND = 8'd5
) (
  input logic       clk,
  input logic       prstb,
  tinydec_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic        ack_q;
  logic [31:0] rdata_q;

  // Working copies: RUN never looks at the live APB registers.
  tea_key_t    wk;
  logic [15:0] wdelta;
  logic [15:0] sum;
  logic [15:0] x;
  logic [15:0] y;
  logic [7:0]  cnt;

  tea_key_t    cfg_key;
  logic [15:0] cfg_delta;
  logic [7:0]  cfg_rounds;

  logic [15:0] y_nxt;
  logic [15:0] x_nxt;

  tinydec_regs #(
    .KEY   (KEY),
    .DELTA (DELTA),
    .ROUND (ROUND)
  ) u_regs (
    .clk     (clk),
    .prstb   (prstb),
    .psel    (bus.psel),
    .penable (bus.penable),
    .pwrite  (bus.pwrite),
    .paddr   (bus.paddr),
    .pwdata  (bus.pwdata),
    .prdata  (bus.prdata),
    .key     (cfg_key),
    .delta   (cfg_delta),
    .rounds  (cfg_rounds)
  );

  assign bus.pready = 1'b1;
  assign bus.ack    = ack_q;
  assign bus.rdata  = rdata_q;

  // y is updated first and its new value feeds the x half-round.
  always_comb begin
    y_nxt = y - tea_f(x, sum, wk.k2, wk.k3);
    x_nxt = x - tea_f(y_nxt, sum, wk.k0, wk.k1);
  end

  // NOTE: the datapath and snapshot registers are reset along with the
  // control state so an aborted block leaves nothing observable behind.
  always_ff @(posedge clk or negedge prstb) begin
    if (!prstb) begin
      state   <= IDLE;
      ack_q   <= 1'b1;
      rdata_q <= '0;
      cnt     <= '0;
      x       <= '0;
      y       <= '0;
      sum     <= '0;
      wk      <= '0;
      wdelta  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            if (cfg_rounds != 8'd0) begin
              x      <= bus.wdata[15:0];
              y      <= bus.wdata[31:16];
              wk     <= cfg_key;
              wdelta <= cfg_delta;
              sum    <= cfg_delta * {8'd0, cfg_rounds};
              cnt    <= cfg_rounds;
              ack_q  <= 1'b0;
              state  <= RUN;
            end else begin
              rdata_q <= bus.wdata;
            end
          end
        end
        RUN: begin
          y   <= y_nxt;
          x   <= x_nxt;
          sum <= sum - wdelta;
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            rdata_q <= {y_nxt, x_nxt};
            ack_q   <= 1'b1;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinydec.sv
// Self-checking bench for tinydec: random plaintexts are encrypted by an
// arithmetic TEA model and must round-trip through the DUT.
`timescale 1ns/1ps
module tb_tinydec;

  localparam logic [63:0] KEY   = 64'h816fc52b09e74da3;
  localparam logic [15:0] DELTA = 16'h1;
  localparam int          ROUND = 5;

  logic clk = 1'b0;
  logic prstb;

  tinydec_if bus ();

  tinydec #(
    .KEY   (KEY),
    .DELTA (DELTA),
    .ROUND (8'(ROUND))
  ) dut (
    .clk   (clk),
    .prstb (prstb),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_key;
  int          m_delta;
  int          m_rounds;

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic int mix(input int v, input int s, input int ka, input int kb);
    return (((v * 16) + ka) % 65536) ^ ((v + s) % 65536) ^ (((v / 32) + kb) % 65536);
  endfunction

  function automatic logic [31:0] enc(input logic [31:0] p, input logic [63:0] k,
                                      input int d, input int n);
    int x, y, s, k0, k1, k2, k3;
    x = int'(p[15:0]);  y = int'(p[31:16]);
    k0 = int'(k[15:0]); k1 = int'(k[31:16]); k2 = int'(k[47:32]); k3 = int'(k[63:48]);
    s = 0;
    for (int i = 0; i < n; i++) begin
      s = (s + d) % 65536;
      x = (x + mix(y, s, k0, k1)) % 65536;
      y = (y + mix(x, s, k2, k3)) % 65536;
    end
    return {16'(y), 16'(x)};
  endfunction

  function automatic logic [31:0] dec(input logic [31:0] c, input logic [63:0] k,
                                      input int d, input int n);
    int x, y, s, k0, k1, k2, k3;
    x = int'(c[15:0]);  y = int'(c[31:16]);
    k0 = int'(k[15:0]); k1 = int'(k[31:16]); k2 = int'(k[47:32]); k3 = int'(k[63:48]);
    s = (d * n) % 65536;
    for (int i = 0; i < n; i++) begin
      y = (y - mix(x, s, k2, k3) + 65536) % 65536;
      x = (x - mix(y, s, k0, k1) + 65536) % 65536;
      s = (s - d + 65536) % 65536;
    end
    return {16'(y), 16'(x)};
  endfunction

  // ---------------- bus drivers ----------------
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    d = bus.prdata;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  // Presents one block for a single edge; low = negedges seen with ack=0.
  task automatic run_block(input logic [31:0] c, output logic [31:0] r, output int low);
    @(negedge clk);
    bus.req = 1'b1; bus.wdata = c;
    @(negedge clk);
    bus.req = 1'b0;
    low = 0;
    while (bus.ack !== 1'b1 && low < 400) begin
      low++;
      @(negedge clk);
    end
    r = bus.rdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    prstb = 1'b0;
    #12;
    n_tests++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL reset_ack: got %b expected 1", bus.ack); end
    n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
    n_tests++; if (bus.prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h expected 0", bus.prdata); end
    n_tests++; if (bus.pready !== 1'b1) begin n_fail++; $display("FAIL pready: got %b expected 1", bus.pready); end
    @(negedge clk);
    prstb = 1'b1;
    apb_read(32'h0, rd);
    n_tests++; if (rd !== KEY[31:0]) begin n_fail++; $display("FAIL reset_key10: got %h expected %h", rd, KEY[31:0]); end
    apb_read(32'h4, rd);
    n_tests++; if (rd !== KEY[63:32]) begin n_fail++; $display("FAIL reset_key32: got %h expected %h", rd, KEY[63:32]); end
    apb_read(32'h8, rd);
    n_tests++; if (rd !== {16'h0, DELTA}) begin n_fail++; $display("FAIL reset_delta: got %h expected %h", rd, {16'h0, DELTA}); end
    apb_read(32'hC, rd);
`ifdef TINYDEC_ROUND_REG_EN
    n_tests++; if (rd !== 32'(ROUND)) begin n_fail++; $display("FAIL reset_rounds: got %h expected %h", rd, 32'(ROUND)); end
`else
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_rounds_absent: got %h expected 0", rd); end
`endif
  endtask

  task automatic test_default_block();
    logic [31:0] p, c, r;
    int low;
    p = 32'h12345678;
    c = enc(p, m_key, m_delta, m_rounds);
    run_block(c, r, low);
    n_tests++; if (r !== p) begin n_fail++; $display("FAIL default_roundtrip: got %h expected %h", r, p); end
    n_tests++; if (low !== m_rounds) begin n_fail++; $display("FAIL default_latency: got %0d expected %0d", low, m_rounds); end
    for (int i = 0; i < 4; i++) begin
      p = $urandom;
      c = enc(p, m_key, m_delta, m_rounds);
      run_block(c, r, low);
      n_tests++; if (r !== p) begin n_fail++; $display("FAIL rand_roundtrip: got %h expected %h", r, p); end
    end
    for (int i = 0; i < 2; i++) begin
      c = $urandom;
      run_block(c, r, low);
      n_tests++; if (r !== dec(c, m_key, m_delta, m_rounds)) begin
        n_fail++; $display("FAIL rand_decrypt: got %h expected %h", r, dec(c, m_key, m_delta, m_rounds));
      end
    end
  endtask

  task automatic test_apb_config();
    logic [31:0] rd, r, c;
    logic [31:0] pats [2];
    int low;
    apb_write(32'h0, 32'hdeadbeef);
    apb_write(32'h4, 32'h01234567);
    apb_write(32'h8, 32'h00009e37);
    m_key = 64'h01234567_deadbeef;
    m_delta = 32'h9e37;
    apb_read(32'h0, rd);
    n_tests++; if (rd !== 32'hdeadbeef) begin n_fail++; $display("FAIL rd_key10: got %h expected deadbeef", rd); end
    apb_read(32'h4, rd);
    n_tests++; if (rd !== 32'h01234567) begin n_fail++; $display("FAIL rd_key32: got %h expected 01234567", rd); end
    apb_read(32'h8, rd);
    n_tests++; if (rd !== 32'h00009e37) begin n_fail++; $display("FAIL rd_delta: got %h expected 00009e37", rd); end
    apb_write(32'h10, 32'hffffffff);
    apb_read(32'h10, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rd_unmapped: got %h expected 0", rd); end
`ifndef TINYDEC_ROUND_REG_EN
    apb_write(32'hC, 32'h00000077);
    apb_read(32'hC, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rd_rounds_absent: got %h expected 0", rd); end
`endif
    pats[0] = 32'h00000000;
    pats[1] = 32'hffffffff;
    for (int i = 0; i < 2; i++) begin
      c = enc(pats[i], m_key, m_delta, m_rounds);
      run_block(c, r, low);
      n_tests++; if (r !== pats[i]) begin n_fail++; $display("FAIL cfg_roundtrip: got %h expected %h", r, pats[i]); end
    end
  endtask

  task automatic test_key_change_during_run();
    logic [31:0] p, c, r, new_lo, new_hi, rd;
    int low;
    new_lo = $urandom;
    new_hi = $urandom;
    p = $urandom;
    c = enc(p, m_key, m_delta, m_rounds);
    // Key write and req acceptance land on the same edge.
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 32'h0; bus.pwdata = new_lo;
    @(negedge clk);
    bus.penable = 1'b1; bus.req = 1'b1; bus.wdata = c;
    @(negedge clk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.req = 1'b0;
    n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL keychg_busy: got %b expected 0", bus.ack); end
    apb_write(32'h4, new_hi);
    low = 0;
    while (bus.ack !== 1'b1 && low < 50) begin low++; @(negedge clk); end
    n_tests++; if (bus.rdata !== p) begin n_fail++; $display("FAIL keychg_old_key: got %h expected %h", bus.rdata, p); end
    m_key = {new_hi, new_lo};
    apb_read(32'h0, rd);
    n_tests++; if (rd !== new_lo) begin n_fail++; $display("FAIL keychg_rd: got %h expected %h", rd, new_lo); end
    p = $urandom;
    c = enc(p, m_key, m_delta, m_rounds);
    run_block(c, r, low);
    n_tests++; if (r !== p) begin n_fail++; $display("FAIL keychg_new_key: got %h expected %h", r, p); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] p [3];
    logic [31:0] c [3];
    int idx, t, last;
    logic prev_ack;
    for (int i = 0; i < 3; i++) begin
      p[i] = $urandom;
      c[i] = enc(p[i], m_key, m_delta, m_rounds);
    end
    @(negedge clk);
    bus.req = 1'b1; bus.wdata = c[0];
    idx = 0; t = 0; last = 0; prev_ack = 1'b1;
    while (idx < 3 && t < 300) begin
      @(negedge clk);
      t++;
      if (bus.ack === 1'b1 && prev_ack === 1'b0) begin
        n_tests++; if (bus.rdata !== p[idx]) begin n_fail++; $display("FAIL b2b_data%0d: got %h expected %h", idx, bus.rdata, p[idx]); end
        n_tests++; if (t - last !== m_rounds + 1) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", idx, t - last, m_rounds + 1); end
        last = t;
        idx++;
        if (idx < 3) bus.wdata = c[idx];
        else bus.req = 1'b0;
      end
      prev_ack = bus.ack;
    end
    bus.req = 1'b0;
    n_tests++; if (idx !== 3) begin n_fail++; $display("FAIL b2b_timeout: got %0d blocks expected 3", idx); end
  endtask

  task automatic test_req_during_run();
    logic [31:0] p, c;
    int low, idle_bad;
    p = $urandom;
    c = enc(p, m_key, m_delta, m_rounds);
    @(negedge clk);
    bus.req = 1'b1; bus.wdata = c;
    @(negedge clk);
    bus.req = 1'b0;
    low = 1;
    @(negedge clk);
    bus.req = 1'b1; bus.wdata = $urandom;
    if (bus.ack === 1'b0) low++;
    @(negedge clk);
    bus.req = 1'b0;
    while (bus.ack !== 1'b1 && low < 400) begin low++; @(negedge clk); end
    n_tests++; if (bus.rdata !== p) begin n_fail++; $display("FAIL ignore_data: got %h expected %h", bus.rdata, p); end
    n_tests++; if (low !== m_rounds) begin n_fail++; $display("FAIL ignore_latency: got %0d expected %0d", low, m_rounds); end
    idle_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ack !== 1'b1) idle_bad++;
    end
    n_tests++; if (idle_bad !== 0) begin n_fail++; $display("FAIL ignore_no_queue: got %0d busy cycles expected 0", idle_bad); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] p, c, r, rd;
    int low;
    p = $urandom;
    c = enc(p, m_key, m_delta, m_rounds);
    @(negedge clk);
    bus.req = 1'b1; bus.wdata = c;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    prstb = 1'b0;
    #1;
    n_tests++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL midrst_ack: got %b expected 1", bus.ack); end
    n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", bus.rdata); end
    @(negedge clk);
    prstb = 1'b1;
    m_key = KEY;
    m_delta = int'(DELTA);
    m_rounds = ROUND;
    apb_read(32'h4, rd);
    n_tests++; if (rd !== KEY[63:32]) begin n_fail++; $display("FAIL midrst_key: got %h expected %h", rd, KEY[63:32]); end
    p = $urandom;
    c = enc(p, m_key, m_delta, m_rounds);
    run_block(c, r, low);
    n_tests++; if (r !== p) begin n_fail++; $display("FAIL midrst_next: got %h expected %h", r, p); end
  endtask

`ifdef TINYDEC_ROUND_REG_EN
  task automatic test_rounds_reg();
    logic [31:0] p, c, r, rd;
    int low;
    apb_write(32'hC, 32'h0);
    apb_read(32'hC, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rounds_rd0: got %h expected 0", rd); end
    m_rounds = 0;
    c = $urandom;
    run_block(c, r, low);
    n_tests++; if (r !== c) begin n_fail++; $display("FAIL rounds0_data: got %h expected %h", r, c); end
    n_tests++; if (low !== 0) begin n_fail++; $display("FAIL rounds0_ack: got %0d busy expected 0", low); end
    apb_write(32'hC, 32'h000000ff);
    m_rounds = 255;
    p = $urandom;
    c = enc(p, m_key, m_delta, m_rounds);
    run_block(c, r, low);
    n_tests++; if (r !== p) begin n_fail++; $display("FAIL rounds255_data: got %h expected %h", r, p); end
    n_tests++; if (low !== 255) begin n_fail++; $display("FAIL rounds255_latency: got %0d expected 255", low); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.wdata = '0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    m_key = KEY;
    m_delta = int'(DELTA);
    m_rounds = ROUND;
    test_reset();
    test_default_block();
    test_apb_config();
    test_key_change_during_run();
    test_back_to_back();
    test_req_during_run();
    test_reset_mid_run();
`ifdef TINYDEC_ROUND_REG_EN
    test_rounds_reg();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tinydec.md
# tinydec

Decrypting counterpart of the team's 16-bit-half TEA encryptor. Accepts one 32-bit ciphertext word per req/ack handshake and runs the inverse TEA rounds, one round per clock. Returns the plaintext on rdata. Key, delta and (optionally) round count are configured over an APB-style slave port. Unlike the encryptor, that port runs on the same single clock.

## Interface
- KEY, 64'h816fc52b09e74da3, reset key {k3,k2,k1,k0}; must match the paired encryptor
- DELTA, 16'h1, reset round constant
- ROUND, 8'd5, round count used when the runtime round register is compiled out
- clk  in  1  sole clock; datapath and APB both sample on posedge
- prstb  in  1  reset, asynchronous, active-low
- req  in  1  start request, sampled only while ack=1
- wdata  in  32  ciphertext; [15:0]=x, [31:16]=y
- ack  out  1  1=idle/result valid, 0=busy
- rdata  out  32  plaintext; [15:0]=x, [31:16]=y
- psel, penable, pwrite  in  1  APB control
- paddr  in  32  APB address
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  tied 1

## Operation
- States: IDLE (ack=1) and RUN (ack=0). There is no separate DONE state.
- IDLE, req=1 with n≠0 rounds:
  - load x=wdata[15:0], y=wdata[31:16]
  - snapshot k0..k3 and delta into working registers
  - load sum = delta*n mod 2^16 and cnt=n
  - go to RUN
- IDLE, req=1 with n=0: rdata<=wdata on that edge; stay IDLE.
- RUN, each cycle, in order:
  - y -= ((x<<4)+k2) ^ (x+sum) ^ ((x>>5)+k3)
  - x -= ((y_new<<4)+k0) ^ (y_new+sum) ^ ((y_new>>5)+k1)
  - sum -= delta
  - cnt -= 1
- Arithmetic: all operations are 16-bit modulo 2^16. `<<4` truncates to 16 bits and `>>5` is logical.
- RUN exit: when cnt reaches 0, rdata<={y,x} final and the state returns to IDLE.
- req is ignored during RUN; there is no queueing or abort.
- Inverse property: for equal KEY/DELTA/round count, tinydec(tinyenc(P)) = P.
- APB register map:
  - 0x0: {k1,k0}
  - 0x4: {k3,k2}
  - 0x8: {16'h0,delta}
  - other addresses read 0, writes ignored
- APB write: on posedge with psel&penable&pwrite. APB read: prdata updated on every posedge with psel=1.
- APB writes during RUN affect only the next block, because RUN uses the snapshot.

## Timing
- Reset values:
  - ack=1, state IDLE
  - rdata=0, prdata=0, cnt=0
  - k=KEY, delta=DELTA
- req accepted at edge N. ack=0 after edge N; rounds execute at edges N+1..N+n.
- After edge N+n: ack=1 and rdata valid. Latency is n+1 edges from req sample to result.
- A back-to-back req held high is accepted at edge N+n+1. Throughput is one block per n+1 cycles.
- rdata holds its value until the next completion.
- An APB write and a req acceptance on the same edge: the snapshot takes the pre-write register value.
- Reset asserted mid-RUN: aborts immediately to reset values and the partial result is discarded.

## Configuration
- TINYDEC_ROUND_REG_EN defined:
  - adds an R/W register at 0xC, {24'h0,rounds}, reset to ROUND
  - n is snapshotted from this register at acceptance
- Not defined:
  - n = ROUND
  - 0xC reads 0 and ignores writes

## Structure
- Shared package tea_pkg holds:
  - address constants TEA_ADDR_KEY10/KEY32/DELTA/ROUNDS
  - a 16-bit half-round function f(v,sum,ka,kb) = ((v<<4)+ka)^(v+sum)^((v>>5)+kb), shared with the encryptor
- One sub-module, tinydec_regs, holds the APB register file and read mux.
- tinydec contains the FSM, snapshot and round datapath.

## Test plan
- Reset defaults, then wdata=32'h12345678 encrypted by the encryptor (defaults, 5 rounds) fed to req → ack low 5 cycles, rdata=32'h12345678.
- Write 0x0=32'hdeadbeef, 0x4=32'h01234567, 0x8=32'h9e37, then round-trip 32'h00000000 and 32'hffffffff → plaintext recovered. Reads of 0x0/0x4/0x8 return the written values; 0xC without the macro returns 0.
- Keys rewritten via APB during RUN → current result uses old keys (round-trips correctly); next block uses new keys.
- req held high for 3 blocks → acceptances exactly n+1 cycles apart, each rdata correct. req pulsed during RUN is ignored.
- prstb pulsed low at round 3 → ack=1 and rdata=0 immediately; next block decrypts correctly.
- With TINYDEC_ROUND_REG_EN: rounds=0 → rdata=wdata after one edge with ack never dropping; rounds=255 → round-trip correct, ack low 255 cycles.
